// File: rtl/dpram_rr_arbiter_if.sv
// Requester-side bus of the dual-port RAM arbiter: one request/response lane per requester,
// packed into flat vectors (requester i at slice i).
interface dpram_rr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_we;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ*WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/dpram_rr_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM among NREQ requesters: up to two grants
// per cycle (port A, port B), address-conflict aware, read data routed back one cycle later.
module dpram_rr_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  dpram_rr_arbiter_if.slave bus,
  output logic             ram_w_en_a,
  output logic             ram_w_en_b,
  output logic [AW-1:0]    ram_addr_a,
  output logic [AW-1:0]    ram_addr_b,
  output logic [WIDTH-1:0] ram_data_in_a,
  output logic [WIDTH-1:0] ram_data_in_b,
  input  logic [WIDTH-1:0] ram_data_out_a,
  input  logic [WIDTH-1:0] ram_data_out_b
);

  localparam int             PW     = $clog2(NREQ);
  localparam logic [PW:0]    NREQ_W = (PW+1)'(NREQ);
  localparam logic [PW-1:0]  LAST_W = PW'(NREQ - 1);

  logic [AW-1:0]    addr_arr  [NREQ];
  logic [WIDTH-1:0] wdata_arr [NREQ];

  logic [PW-1:0]    ptr_reg, ptr_next;
  logic             rd_pend_a_reg, rd_pend_b_reg;
  logic [PW-1:0]    rd_id_a_reg, rd_id_b_reg;

  logic             gnt_a_vld, gnt_b_vld;
  logic [PW-1:0]    gnt_a_id, gnt_b_id;
  logic [PW:0]      idx_sum;
  logic [PW-1:0]    idx;
  logic [PW-1:0]    last_id;
  logic [NREQ-1:0]  ready_vec;

  function automatic logic conflicts(input logic [AW-1:0] addr0, input logic we0,
                                     input logic [AW-1:0] addr1, input logic we1);
    return (addr0 == addr1) && (we0 || we1);
  endfunction

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = bus.req_addr[gi*AW +: AW];
    assign wdata_arr[gi] = bus.req_wdata[gi*WIDTH +: WIDTH];
  end

  // Rotating scan from ptr: first valid -> A, next valid not clashing with A -> B.
  always_comb begin
    gnt_a_vld = 1'b0;
    gnt_a_id  = '0;
    gnt_b_vld = 1'b0;
    gnt_b_id  = '0;
    idx_sum   = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_sum = {1'b0, ptr_reg} + (PW+1)'(k);
      if (idx_sum >= NREQ_W) begin
        idx_sum = idx_sum - NREQ_W;
      end
      idx = idx_sum[PW-1:0];
      if (bus.req_valid[idx]) begin
        if (!gnt_a_vld) begin
          gnt_a_vld = 1'b1;
          gnt_a_id  = idx;
        end else if (!gnt_b_vld &&
                     !conflicts(addr_arr[gnt_a_id], bus.req_we[gnt_a_id],
                                addr_arr[idx], bus.req_we[idx])) begin
          gnt_b_vld = 1'b1;
          gnt_b_id  = idx;
        end
      end
    end
  end

  always_comb begin
    last_id  = gnt_b_vld ? gnt_b_id : gnt_a_id;
    ptr_next = ptr_reg;
    if (gnt_a_vld) begin
      ptr_next = (last_id == LAST_W) ? '0 : last_id + 1'b1;
    end
  end

  // Idle ports issue a benign read of address 0 whose data is never routed anywhere.
  assign ram_w_en_a    = gnt_a_vld & bus.req_we[gnt_a_id];
  assign ram_addr_a    = gnt_a_vld ? addr_arr[gnt_a_id]  : '0;
  assign ram_data_in_a = gnt_a_vld ? wdata_arr[gnt_a_id] : '0;
  assign ram_w_en_b    = gnt_b_vld & bus.req_we[gnt_b_id];
  assign ram_addr_b    = gnt_b_vld ? addr_arr[gnt_b_id]  : '0;
  assign ram_data_in_b = gnt_b_vld ? wdata_arr[gnt_b_id] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg       <= '0;
      rd_pend_a_reg <= 1'b0;
      rd_id_a_reg   <= '0;
      rd_pend_b_reg <= 1'b0;
      rd_id_b_reg   <= '0;
    end else begin
      ptr_reg       <= ptr_next;
      rd_pend_a_reg <= gnt_a_vld & ~bus.req_we[gnt_a_id];
      rd_id_a_reg   <= gnt_a_id;
      rd_pend_b_reg <= gnt_b_vld & ~bus.req_we[gnt_b_id];
      rd_id_b_reg   <= gnt_b_id;
    end
  end

  // A requester never holds both ports in one cycle, so at most one hit per slice.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    logic hit_a, hit_b;
    assign hit_a         = rd_pend_a_reg && (rd_id_a_reg == PW'(gi));
    assign hit_b         = rd_pend_b_reg && (rd_id_b_reg == PW'(gi));
    assign ready_vec[gi] = (gnt_a_vld && (gnt_a_id == PW'(gi))) ||
                           (gnt_b_vld && (gnt_b_id == PW'(gi)));
    assign bus.rsp_valid[gi] = hit_a | hit_b;
    assign bus.rsp_data[gi*WIDTH +: WIDTH] = hit_a ? ram_data_out_a :
                                             hit_b ? ram_data_out_b : '0;
  end

  assign bus.req_ready = ready_vec;

endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// Bench for dpram_rr_arbiter: queued requesters, an attached RAM, and a per-cycle
// reference model of grants, RAM port drive and responses.
module tb_dpram_rr_arbiter;
  localparam int NREQ  = 4;
  localparam int DEPTH = 16;
  localparam int WIDTH = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int QLEN  = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dpram_rr_arbiter_if #(.NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  logic             ram_w_en_a, ram_w_en_b;
  logic [AW-1:0]    ram_addr_a, ram_addr_b;
  logic [WIDTH-1:0] ram_data_in_a, ram_data_in_b;
  logic [WIDTH-1:0] ram_data_out_a, ram_data_out_b;

  dpram_rr_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ram_w_en_a(ram_w_en_a), .ram_w_en_b(ram_w_en_b),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_data_in_a(ram_data_in_a), .ram_data_in_b(ram_data_in_b),
    .ram_data_out_a(ram_data_out_a), .ram_data_out_b(ram_data_out_b)
  );

  // Attached dual-port RAM, registered read.
  logic [WIDTH-1:0] ram [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    ram_data_out_a = '0;
    ram_data_out_b = '0;
  end
  always @(posedge clk) begin
    if (ram_w_en_a) ram[ram_addr_a] <= ram_data_in_a;
    if (ram_w_en_b) ram[ram_addr_b] <= ram_data_in_b;
    ram_data_out_a <= ram[ram_addr_a];
    ram_data_out_b <= ram[ram_addr_b];
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  logic [WIDTH-1:0]      ref_mem [DEPTH];
  int                    mptr = 0;
  logic [NREQ-1:0]       exp_rv = '0;
  logic [NREQ*WIDTH-1:0] exp_rd = '0;
  logic [NREQ-1:0]       seen_ready = '0;
  logic [NREQ-1:0]       ready_log [1024];
  int                    n_log = 0;
  int                    rsp_cnt [NREQ];
  logic [WIDTH-1:0]      rsp_last [NREQ];

  function automatic logic clash(input int a, input int b);
    return (bus.req_addr[a*AW +: AW] == bus.req_addr[b*AW +: AW]) &&
           (bus.req_we[a] || bus.req_we[b]);
  endfunction

  function automatic logic [AW+WIDTH:0] port_exp(input int g);
    if (g < 0) return '0;
    return {bus.req_we[g], bus.req_addr[g*AW +: AW], bus.req_wdata[g*WIDTH +: WIDTH]};
  endfunction

  initial begin
    int cur_ptr, ga, gb, r;
    logic [NREQ-1:0]       cv, nv, eready;
    logic [NREQ*WIDTH-1:0] cd, nd;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    for (int i = 0; i < NREQ; i++) begin rsp_cnt[i] = 0; rsp_last[i] = '0; end
    forever begin
      @(negedge clk);
      if (!rst_n) begin cur_ptr = 0; cv = '0; cd = '0; end
      else begin cur_ptr = mptr; cv = exp_rv; cd = exp_rd; end
      ga = -1; gb = -1;
      for (int k = 0; k < NREQ; k++) begin
        r = (cur_ptr + k) % NREQ;
        if (bus.req_valid[r]) begin
          if (ga < 0) ga = r;
          else if (gb < 0 && !clash(ga, r)) gb = r;
        end
      end
      eready = '0;
      if (ga >= 0) eready[ga] = 1'b1;
      if (gb >= 0) eready[gb] = 1'b1;
      chk("req_ready", bus.req_ready, eready);
      chk("ram_port_a", {ram_w_en_a, ram_addr_a, ram_data_in_a}, port_exp(ga));
      chk("ram_port_b", {ram_w_en_b, ram_addr_b, ram_data_in_b}, port_exp(gb));
      chk("rsp_valid", bus.rsp_valid, cv);
      chk("rsp_data", bus.rsp_data, cd);
      seen_ready = bus.req_ready & bus.req_valid;
      if (|bus.req_valid && n_log < 1024) begin
        ready_log[n_log] = bus.req_ready;
        n_log++;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bus.rsp_valid[i]) begin
          rsp_cnt[i]++;
          rsp_last[i] = bus.rsp_data[i*WIDTH +: WIDTH];
        end
      end
      nv = '0; nd = '0;
      if (ga >= 0 && !bus.req_we[ga]) begin
        nv[ga] = 1'b1;
        nd[ga*WIDTH +: WIDTH] = ref_mem[bus.req_addr[ga*AW +: AW]];
      end
      if (gb >= 0 && !bus.req_we[gb]) begin
        nv[gb] = 1'b1;
        nd[gb*WIDTH +: WIDTH] = ref_mem[bus.req_addr[gb*AW +: AW]];
      end
      @(posedge clk);
      if (!rst_n) begin
        mptr = 0; exp_rv = '0; exp_rd = '0;
      end else begin
        if (ga >= 0 && bus.req_we[ga]) ref_mem[bus.req_addr[ga*AW +: AW]] = bus.req_wdata[ga*WIDTH +: WIDTH];
        if (gb >= 0 && bus.req_we[gb]) ref_mem[bus.req_addr[gb*AW +: AW]] = bus.req_wdata[gb*WIDTH +: WIDTH];
        exp_rv = nv;
        exp_rd = nd;
        if (gb >= 0) mptr = (gb + 1) % NREQ;
        else if (ga >= 0) mptr = (ga + 1) % NREQ;
      end
    end
  end

  // ---------------- requester queues and stimulus ----------------
  logic             op_we    [NREQ][QLEN];
  logic [AW-1:0]    op_addr  [NREQ][QLEN];
  logic [WIDTH-1:0] op_wdata [NREQ][QLEN];
  int head [NREQ];
  int tail [NREQ];

  task automatic push(input int r, input logic we, input int addr, input int data);
    op_we[r][tail[r]]    = we;
    op_addr[r][tail[r]]  = AW'(addr);
    op_wdata[r][tail[r]] = WIDTH'(data);
    tail[r]++;
  endtask

  task automatic drive();
    for (int r = 0; r < NREQ; r++) begin
      if (head[r] < tail[r]) begin
        bus.req_valid[r]              = 1'b1;
        bus.req_we[r]                 = op_we[r][head[r]];
        bus.req_addr[r*AW +: AW]      = op_addr[r][head[r]];
        bus.req_wdata[r*WIDTH +: WIDTH] = op_wdata[r][head[r]];
      end else begin
        bus.req_valid[r]              = 1'b0;
        bus.req_we[r]                 = 1'b0;
        bus.req_addr[r*AW +: AW]      = '0;
        bus.req_wdata[r*WIDTH +: WIDTH] = '0;
      end
    end
  endtask

  function automatic logic busy();
    for (int r = 0; r < NREQ; r++) if (head[r] < tail[r]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step();
    @(posedge clk); #1;
    for (int r = 0; r < NREQ; r++)
      if (seen_ready[r] && head[r] < tail[r]) head[r]++;
    drive();
  endtask

  task automatic run(input int budget);
    int c = 0;
    drive();
    while (busy() && c < budget) begin step(); c++; end
    chk("drain_within_budget", busy(), 1'b0);
    for (int r = 0; r < NREQ; r++) head[r] = tail[r];
    step(); step();
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lb;
    int base [NREQ];
    rst_n = 1'b1;
    for (int r = 0; r < NREQ; r++) begin head[r] = 0; tail[r] = 0; end
    drive();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: write then read of the same address by req0
    lb = n_log; base[0] = rsp_cnt[0];
    push(0, 1'b1, 3, 'hBEEF); push(0, 1'b0, 3, 0);
    run(20);
    chk("t1_wr_ready", ready_log[lb], 4'b0001);
    chk("t1_rd_ready", ready_log[lb+1], 4'b0001);
    chk("t1_rsp_cnt", rsp_cnt[0] - base[0], 1);
    chk("t1_rsp_data", rsp_last[0], 16'hBEEF);

    // 2: all four read distinct addresses from ptr=0
    do_reset();
    for (int r = 0; r < NREQ; r++) push(r, 1'b1, 8 + r, 'hA000 + r);
    run(20);
    lb = n_log;
    for (int r = 0; r < NREQ; r++) base[r] = rsp_cnt[r];
    for (int rep = 0; rep < 2; rep++)
      for (int r = 0; r < NREQ; r++) push(r, 1'b0, 8 + r, 0);
    run(20);
    chk("t2_grant0", ready_log[lb],   4'b0011);
    chk("t2_grant1", ready_log[lb+1], 4'b1100);
    chk("t2_grant2", ready_log[lb+2], 4'b0011);
    chk("t2_grant3", ready_log[lb+3], 4'b1100);
    for (int r = 0; r < NREQ; r++) begin
      chk("t2_rsp_cnt", rsp_cnt[r] - base[r], 2);
      chk("t2_rsp_data", rsp_last[r], 16'hA000 + 16'(r));
    end

    // 3: two writes to the same address are serialised
    lb = n_log;
    push(0, 1'b1, 5, 'h1111); push(1, 1'b1, 5, 'h2222);
    run(20);
    chk("t3_grant0", ready_log[lb],   4'b0001);
    chk("t3_grant1", ready_log[lb+1], 4'b0010);
    lb = n_log; base[3] = rsp_cnt[3];
    push(3, 1'b0, 5, 0);
    run(20);
    chk("t3_rd_ready", ready_log[lb], 4'b1000);
    chk("t3_rsp_cnt", rsp_cnt[3] - base[3], 1);
    chk("t3_rsp_data", rsp_last[3], 16'h2222);

    // 4: write/read clash on the same address
    lb = n_log; base[2] = rsp_cnt[2];
    push(0, 1'b1, 7, 'h1234); push(2, 1'b0, 7, 0);
    run(20);
    chk("t4_grant0", ready_log[lb],   4'b0001);
    chk("t4_grant1", ready_log[lb+1], 4'b0100);
    chk("t4_rsp_cnt", rsp_cnt[2] - base[2], 1);
    chk("t4_rsp_data", rsp_last[2], 16'h1234);

    // 5: reset between a read grant and its response
    base[1] = rsp_cnt[1];
    push(1, 1'b0, 3, 0);
    drive();
    @(negedge clk);
    chk("t5_ready", bus.req_ready, 4'b0010);
    #2 rst_n = 1'b0;
    for (int r = 0; r < NREQ; r++) head[r] = tail[r];
    drive();
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_rsp_valid_in_reset", bus.rsp_valid, 4'b0000);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_no_rsp", rsp_cnt[1] - base[1], 0);
    lb = n_log;
    for (int r = 0; r < NREQ; r++) push(r, 1'b0, 8 + r, 0);
    run(20);
    chk("t5_ptr0_grant0", ready_log[lb],   4'b0011);
    chk("t5_ptr0_grant1", ready_log[lb+1], 4'b1100);

    // 6: idle cycles keep ptr
    lb = n_log;
    push(1, 1'b0, 9, 0); push(2, 1'b0, 10, 0);
    run(20);
    chk("t6_pre_grant", ready_log[lb], 4'b0110);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_idle_ready", bus.req_ready, 4'b0000);
      chk("t6_idle_wen", {ram_w_en_a, ram_w_en_b}, 2'b00);
      @(posedge clk); #1;
    end
    lb = n_log;
    for (int r = 0; r < NREQ; r++) push(r, 1'b0, 8 + r, 0);
    run(20);
    chk("t6_ptr_held", ready_log[lb], 4'b1001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
